// File: rtl/fsub_pipe.sv
// Three-stage pipelined IEEE-754 single-precision subtractor, y = x1 - x2, round-to-nearest-even.
// Define FSUB_FTZ_EN to flush subnormal inputs and results to signed zero.
module fsub_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [4:0] lzc26(input logic [25:0] v);
    lzc26 = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) lzc26 = 5'(25 - i);
    end
  endfunction

  logic advance;
  logic s1_valid, s2_valid, s3_valid;

  // S1 unpack / align
  logic        sa, sb;
  logic [7:0]  ea, eb, ea_f, eb_f, el, es, diff;
  logic [23:0] ma, mb, ml, ms;
  logic        sl, a_ge;
  logic [4:0]  sh1;
  logic [56:0] shifted;
  logic        a_nan, b_nan, a_inf, b_inf, spec1;
  logic [31:0] spec_y1;

  logic             s1_spec, s1_sign, s1_sticky, s1_sub, s1_zsign;
  logic [31:0]      s1_spec_y;
  logic [7:0]       s1_exp;
  logic [25:0]      s1_lm, s1_sm;
  logic [TAG_W-1:0] s1_tag;

  // S2 add/sub + lzc
  logic [26:0] sum27;
  logic        carry2, st2, zero2;
  logic [25:0] man2;
  logic [8:0]  exp2;
  logic [4:0]  lzc2;

  logic             s2_spec, s2_sign, s2_sticky, s2_zero, s2_zsign;
  logic [31:0]      s2_spec_y;
  logic [8:0]       s2_exp;
  logic [25:0]      s2_man;
  logic [4:0]       s2_lzc;
  logic [TAG_W-1:0] s2_tag;

  // S3 normalize / round / pack
  logic [9:0]  e10, en, ef;
  logic [4:0]  sh3;
  logic [25:0] norm;
  logic [23:0] m24;
  logic [24:0] m25;
  logic        rup;
  logic [22:0] frac;
  logic [31:0] y3;
  logic        ovf3;
`ifdef FSUB_FTZ_EN
  logic        uflow;
`else
  logic [9:0]  lim;
`endif

  assign advance   = !s3_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid;

  assign sa = x1[31];
  assign sb = ~x2[31];
  assign ea = x1[30:23];
  assign eb = x2[30:23];

  always_comb begin
    ea_f = (ea == 8'd0) ? 8'd1 : ea;
    eb_f = (eb == 8'd0) ? 8'd1 : eb;
`ifdef FSUB_FTZ_EN
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, x1[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, x2[22:0]};
`else
    ma = {ea != 8'd0, x1[22:0]};
    mb = {eb != 8'd0, x2[22:0]};
`endif
    a_ge = {ea_f, ma} >= {eb_f, mb};
    if (a_ge) begin
      sl = sa; el = ea_f; ml = ma; es = eb_f; ms = mb;
    end else begin
      sl = sb; el = eb_f; ml = mb; es = ea_f; ms = ma;
    end
    diff    = el - es;
    sh1     = (diff > 8'd31) ? 5'd31 : diff[4:0];
    // Smaller mantissa lands in [56:31] (24 bits + 2 guard); everything below is sticky
    shifted = {ms, 33'd0} >> sh1;

    a_nan   = (ea == 8'hff) && (x1[22:0] != 23'd0);
    b_nan   = (eb == 8'hff) && (x2[22:0] != 23'd0);
    a_inf   = (ea == 8'hff) && (x1[22:0] == 23'd0);
    b_inf   = (eb == 8'hff) && (x2[22:0] == 23'd0);
    spec1   = 1'b1;
    spec_y1 = 32'd0;
    if (b_nan)               spec_y1 = {sb, 8'hff, 1'b1, x2[21:0]};
    else if (a_nan)          spec_y1 = {sa, 8'hff, 1'b1, x1[21:0]};
    else if (a_inf && b_inf) spec_y1 = (sa != sb) ? 32'hffc0_0000 : {sa, 8'hff, 23'd0};
    else if (a_inf)          spec_y1 = {sa, 8'hff, 23'd0};
    else if (b_inf)          spec_y1 = {sb, 8'hff, 23'd0};
    else                     spec1   = 1'b0;
  end

  // A sticky bit on a subtraction borrows one guard-LSB and stays set,
  // which keeps the residue exact for rounding.
  always_comb begin
    if (s1_sub) sum27 = {1'b0, s1_lm} - {1'b0, s1_sm} - {26'd0, s1_sticky};
    else        sum27 = {1'b0, s1_lm} + {1'b0, s1_sm};
    carry2 = !s1_sub && sum27[26];
    man2   = carry2 ? sum27[26:1] : sum27[25:0];
    st2    = s1_sticky | (carry2 & sum27[0]);
    exp2   = {1'b0, s1_exp} + {8'd0, carry2};
    lzc2   = lzc26(man2);
    zero2  = (man2 == 26'd0) && !st2;
  end

  always_comb begin
    e10 = {1'b0, s2_exp};
`ifdef FSUB_FTZ_EN
    sh3   = s2_lzc;
    uflow = {5'd0, s2_lzc} >= e10;
`else
    lim = e10 - 10'd1;
    sh3 = ({5'd0, s2_lzc} > lim) ? lim[4:0] : s2_lzc;
`endif
    norm = s2_man << sh3;
    en   = e10 - {5'd0, sh3};
    m24  = norm[25:2];
    rup  = norm[1] & (norm[0] | s2_sticky | m24[0]);
    m25  = {1'b0, m24} + {24'd0, rup};
    // Leading bit 0 after rounding means subnormal; a carry bumps the exponent
    ef   = m25[24] ? 10'(en + 10'd1) : (m25[23] ? en : 10'd0);
    frac = m25[24] ? 23'd0 : m25[22:0];
    ovf3 = 1'b0;
    if (s2_spec)                y3 = s2_spec_y;
    else if (s2_zero)           y3 = {s2_zsign, 31'd0};
`ifdef FSUB_FTZ_EN
    else if (uflow)             y3 = {s2_sign, 31'd0};
`endif
    else if (ef >= 10'd255) begin
      y3   = {s2_sign, 8'hff, 23'd0};
      ovf3 = 1'b1;
    end
    else                        y3 = {s2_sign, ef[7:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0;
      s1_spec <= 1'b0; s1_spec_y <= 32'd0; s1_sign <= 1'b0; s1_exp <= 8'd0;
      s1_lm <= 26'd0; s1_sm <= 26'd0; s1_sticky <= 1'b0; s1_sub <= 1'b0;
      s1_zsign <= 1'b0; s1_tag <= '0;
      s2_spec <= 1'b0; s2_spec_y <= 32'd0; s2_sign <= 1'b0; s2_exp <= 9'd0;
      s2_man <= 26'd0; s2_sticky <= 1'b0; s2_lzc <= 5'd0; s2_zero <= 1'b0;
      s2_zsign <= 1'b0; s2_tag <= '0;
      y <= 32'd0; ovf <= 1'b0; out_tag <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_spec   <= spec1;
      s1_spec_y <= spec_y1;
      s1_sign   <= sl;
      s1_exp    <= el;
      s1_lm     <= {ml, 2'b00};
      s1_sm     <= shifted[56:31];
      s1_sticky <= |shifted[30:0];
      s1_sub    <= sa ^ sb;
      s1_zsign  <= sa & sb;
      s1_tag    <= in_tag;

      s2_valid  <= s1_valid;
      s2_spec   <= s1_spec;
      s2_spec_y <= s1_spec_y;
      s2_sign   <= s1_sign;
      s2_exp    <= exp2;
      s2_man    <= man2;
      s2_sticky <= st2;
      s2_lzc    <= lzc2;
      s2_zero   <= zero2;
      s2_zsign  <= s1_zsign;
      s2_tag    <= s1_tag;

      s3_valid  <= s2_valid;
      y         <= y3;
      ovf       <= ovf3;
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Directed self-checking bench for fsub_pipe: arithmetic vectors, backpressure and reset flush.
module tb_fsub_pipe;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;
  logic [3:0]  in_tag, out_tag;
  int vecs = 0;
  int errs = 0;

  fsub_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Issue one op into a drained pipe and return the result and its latency in edges (-1 on timeout)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        output logic [31:0] ry, output logic ro, output logic [3:0] rt,
                        output int lat);
    @(negedge clk);
    x1 = a; x2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    ry = y; ro = ovf; rt = out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vecs++; if (y !== 32'd0) begin errs++; $display("FAIL reset_y: got %h want 00000000", y); end
    vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    vecs++; if (out_tag !== 4'd0) begin errs++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] ry; logic ro; logic [3:0] rt; int lat;
    run_op(32'h4040_0000, 32'h3F80_0000, 4'd5, ry, ro, rt, lat);
    vecs++; if (ry !== 32'h4000_0000) begin errs++; $display("FAIL basic_y: got %h want 40000000", ry); end
    vecs++; if (rt !== 4'd5) begin errs++; $display("FAIL basic_tag: got %0d want 5", rt); end
    vecs++; if (ro !== 1'b0) begin errs++; $display("FAIL basic_ovf: got %b want 0", ro); end
    vecs++; if (lat != 3) begin errs++; $display("FAIL basic_latency: got %0d want 3", lat); end
  endtask

  task automatic test_zero();
    logic [31:0] ry; logic ro; logic [3:0] rt; int lat;
    run_op(32'h3F80_0000, 32'h3F80_0000, 4'd1, ry, ro, rt, lat);
    vecs++; if (ry !== 32'h0000_0000) begin errs++; $display("FAIL zero_x_minus_x: got %h want 00000000", ry); end
    run_op(32'h8000_0000, 32'h0000_0000, 4'd2, ry, ro, rt, lat);
    vecs++; if (ry !== 32'h8000_0000) begin errs++; $display("FAIL zero_neg: got %h want 80000000", ry); end
  endtask

  task automatic test_overflow();
    logic [31:0] ry; logic ro; logic [3:0] rt; int lat;
    run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 4'd3, ry, ro, rt, lat);
    vecs++; if (ry !== 32'h7F80_0000) begin errs++; $display("FAIL ovf_y: got %h want 7f800000", ry); end
    vecs++; if (ro !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b want 1", ro); end
    run_op(32'h7F80_0000, 32'h7F80_0000, 4'd4, ry, ro, rt, lat);
    vecs++; if (ry !== 32'hFFC0_0000) begin errs++; $display("FAIL inf_minus_inf_y: got %h want ffc00000", ry); end
    vecs++; if (ro !== 1'b0) begin errs++; $display("FAIL inf_minus_inf_ovf: got %b want 0", ro); end
  endtask

  task automatic test_subnormal();
    logic [31:0] ry, exp_y; logic ro; logic [3:0] rt; int lat;
`ifdef FSUB_FTZ_EN
    exp_y = 32'h0080_0000;
`else
    exp_y = 32'h007F_FFFF;
`endif
    run_op(32'h0080_0000, 32'h0000_0001, 4'd6, ry, ro, rt, lat);
    vecs++; if (ry !== exp_y) begin errs++; $display("FAIL subnormal_y: got %h want %h", ry, exp_y); end
    vecs++; if (ro !== 1'b0) begin errs++; $display("FAIL subnormal_ovf: got %b want 0", ro); end
  endtask

  task automatic test_rounding_specials();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] vy [9];
    logic [31:0] ry; logic ro; logic [3:0] rt; int lat;
    va[0] = 32'h3F80_0000; vb[0] = 32'h4040_0000; vy[0] = 32'hC000_0000; // 1 - 3
    va[1] = 32'h3FC0_0000; vb[1] = 32'hC020_0000; vy[1] = 32'h4080_0000; // 1.5 - (-2.5)
    va[2] = 32'h3F80_0000; vb[2] = 32'h3380_0000; vy[2] = 32'h3F7F_FFFF; // 1 - 2^-24, exact
    va[3] = 32'h3F80_0000; vb[3] = 32'hB380_0000; vy[3] = 32'h3F80_0000; // tie, even stays
    va[4] = 32'h3F80_0001; vb[4] = 32'hB380_0000; vy[4] = 32'h3F80_0002; // tie, odd rounds up
    va[5] = 32'h3F80_0000; vb[5] = 32'h3080_0000; vy[5] = 32'h3F80_0000; // sticky-only borrow
    va[6] = 32'h7F80_0001; vb[6] = 32'h3F80_0000; vy[6] = 32'h7FC0_0001; // NaN quieted
    va[7] = 32'h3F80_0000; vb[7] = 32'h7F80_0000; vy[7] = 32'hFF80_0000; // 1 - inf
    va[8] = 32'h7F80_0000; vb[8] = 32'hFF80_0000; vy[8] = 32'h7F80_0000; // inf - (-inf)
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], 4'(i), ry, ro, rt, lat);
      vecs++; if (ry !== vy[i]) begin errs++; $display("FAIL round_y[%0d]: got %h want %h", i, ry, vy[i]); end
      vecs++; if (ro !== 1'b0) begin errs++; $display("FAIL round_ovf[%0d]: got %b want 0", i, ro); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bx1 [5];
    logic [31:0] bx2 [5];
    logic [31:0] by [5];
    logic [31:0] held;
    int acc, got, first, last;
    bx1[0] = 32'h4000_0000; bx2[0] = 32'h3F80_0000; by[0] = 32'h3F80_0000;
    bx1[1] = 32'h4040_0000; bx2[1] = 32'h3F80_0000; by[1] = 32'h4000_0000;
    bx1[2] = 32'h4080_0000; bx2[2] = 32'h3F80_0000; by[2] = 32'h4040_0000;
    bx1[3] = 32'h3F80_0000; bx2[3] = 32'h3F80_0000; by[3] = 32'h0000_0000;
    bx1[4] = 32'h4040_0000; bx2[4] = 32'hBF80_0000; by[4] = 32'h4080_0000;
    acc = 0; got = 0; first = -1; last = -1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      x1 = bx1[acc]; x2 = bx2[acc]; in_tag = 4'(acc + 1); in_valid = 1'b1;
      #1;
      if (in_ready && in_valid) acc++;
      @(posedge clk);
    end
    #1;
    vecs++; if (acc != 3) begin errs++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    held = y;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (y !== held) begin errs++; $display("FAIL bp_y_stable: got %h want %h", y, held); end
    vecs++; if (y !== by[0]) begin errs++; $display("FAIL bp_y_held: got %h want %h", y, by[0]); end
    for (int c = 0; c < 16; c++) begin
      if (got < 5) begin
        @(negedge clk);
        out_ready = 1'b1;
        if (acc < 5) begin
          x1 = bx1[acc]; x2 = bx2[acc]; in_tag = 4'(acc + 1); in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (in_ready && in_valid) acc++;
        if (out_valid) begin
          vecs++; if (y !== by[got]) begin errs++; $display("FAIL bp_y[%0d]: got %h want %h", got, y, by[got]); end
          vecs++; if (out_tag !== 4'(got + 1)) begin errs++; $display("FAIL bp_tag[%0d]: got %0d want %0d", got, out_tag, got + 1); end
          if (first < 0) first = c;
          last = c;
          got++;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    vecs++; if (got != 5) begin errs++; $display("FAIL bp_results: got %0d want 5", got); end
    vecs++; if (last - first != 4) begin errs++; $display("FAIL bp_rate: got span %0d want 4", last - first); end
  endtask

  task automatic test_reset_flush();
    logic [31:0] ry; logic ro; logic [3:0] rt; int lat, seen;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x1 = 32'h7F7F_FFFF; x2 = 32'hFF7F_FFFF; in_tag = 4'(7 + i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    vecs++; if (y !== 32'd0) begin errs++; $display("FAIL flush_y: got %h want 00000000", y); end
    vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL flush_ovf: got %b want 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vecs++; if (seen != 0) begin errs++; $display("FAIL flush_leak: got %0d results want 0", seen); end
    run_op(32'h4040_0000, 32'h3F80_0000, 4'hA, ry, ro, rt, lat);
    vecs++; if (ry !== 32'h4000_0000) begin errs++; $display("FAIL flush_new_y: got %h want 40000000", ry); end
    vecs++; if (rt !== 4'hA) begin errs++; $display("FAIL flush_new_tag: got %h want a", rt); end
    vecs++; if (lat != 3) begin errs++; $display("FAIL flush_new_latency: got %0d want 3", lat); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x1 = 32'd0; x2 = 32'd0; in_tag = 4'd0;
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_subnormal();
    test_rounding_specials();
    test_backpressure();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
